// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, framer state encoding and keep-vector helper
// for the 10GBASE-R transmit framer.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_ERROR    = 8'hFE;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  // Lane 0 sits in bits [7:0], so concatenations list lane 7 first.
  localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
  localparam logic [63:0] ERROR_WORD = {8{XGMII_ERROR}};
  localparam logic [63:0] START_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
  localparam logic [63:0] TERM_WORD  = {{7{XGMII_IDLE}}, XGMII_TERM};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TERM  = 2'd2,
    ST_DRAIN = 2'd3
  } framer_state_e;

  typedef struct packed {
    logic [3:0] count;
    logic       contiguous;
  } keep_info_t;

  // contiguous is set only for a nonzero run of ones starting at lane 0.
  function automatic keep_info_t keep_lanes(input logic [7:0] keep);
    keep_info_t info;
    info.count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      info.count = info.count + {3'd0, keep[i]};
    end
    info.contiguous = (keep != 8'h00) && ((keep & (keep + 8'd1)) == 8'h00);
    return info;
  endfunction

endpackage

// File: rtl/xgmii_tx_framer_if.sv
// Packet-beat input stream and XGMII output bus of the transmit framer.
interface xgmii_tx_framer_if;
  // Handshake: a beat transfers on a rising clock edge where s_valid && s_ready.
  // The source holds s_data/s_keep/s_last stable while s_valid is high and the
  // beat has not transferred; s_ready depends only on framer state, never on s_valid.
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;

  modport master (
    output s_data, s_keep, s_valid, s_last,
    input  s_ready, xgmii_txd, xgmii_txc
  );

  modport slave (
    input  s_data, s_keep, s_valid, s_last,
    output s_ready, xgmii_txd, xgmii_txc
  );
endinterface

// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps packet beats in start/preamble and terminate,
// enforces the inter-frame idle gap and turns underruns/bad keeps into error words.
module xgmii_tx_framer
  import xgmii_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_156,
  input  logic                 rst_156_n,
  xgmii_tx_framer_if.slave     tx,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output framer_state_e        state_dbg
);

  localparam int CRW = $clog2(IFG_BYTES + 9);
  localparam logic [CRW-1:0] IFG_C   = CRW'(IFG_BYTES);
  localparam logic [CRW-1:0] EIGHT_C = CRW'(8);

  framer_state_e  state, state_n;
  logic [CRW-1:0] credit, credit_n, credit_sat;
  logic [CRW:0]   credit_sum;
  logic [63:0]    txd_q, txd_n;
  logic [7:0]     txc_q, txc_n;
  logic           frame_inc, err_inc, keep_bad;
  keep_info_t     ki;

  // Credit counts idle bytes sent since the last start, saturating at the gap size.
  assign credit_sum = {1'b0, credit} + {1'b0, EIGHT_C};
  assign credit_sat = (credit_sum >= {1'b0, IFG_C}) ? IFG_C : credit_sum[CRW-1:0];

  assign ki       = keep_lanes(tx.s_keep);
  assign keep_bad = tx.s_last ? !ki.contiguous : (tx.s_keep != 8'hFF);

  assign tx.s_ready   = (state == ST_DATA) || (state == ST_DRAIN);
  assign tx.xgmii_txd = txd_q;
  assign tx.xgmii_txc = txc_q;
  assign state_dbg    = state;

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    txd_n     = IDLE_WORD;
    txc_n     = 8'hFF;
    frame_inc = 1'b0;
    err_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx.s_valid && (credit >= IFG_C)) begin
          txd_n    = START_WORD;
          txc_n    = 8'h01;
          credit_n = '0;
          state_n  = ST_DATA;
        end else begin
          credit_n = credit_sat;
        end
      end
      ST_DATA: begin
        if (!tx.s_valid) begin
          txd_n   = ERROR_WORD;
          err_inc = 1'b1;
          state_n = ST_DRAIN;
        end else if (keep_bad) begin
          txd_n   = ERROR_WORD;
          err_inc = 1'b1;
          state_n = tx.s_last ? ST_IDLE : ST_DRAIN;
        end else if (!tx.s_last || (ki.count == 4'd8)) begin
          txd_n   = tx.s_data;
          txc_n   = 8'h00;
          state_n = tx.s_last ? ST_TERM : ST_DATA;
        end else begin
          // Short last beat: terminate in the first unused lane, idle above it.
          for (int i = 0; i < 8; i++) begin
            if (i < int'(ki.count)) begin
              txd_n[8*i +: 8] = tx.s_data[8*i +: 8];
            end else if (i == int'(ki.count)) begin
              txd_n[8*i +: 8] = XGMII_TERM;
            end else begin
              txd_n[8*i +: 8] = XGMII_IDLE;
            end
          end
          txc_n     = 8'hFF << ki.count;
          credit_n  = EIGHT_C - CRW'(ki.count);
          frame_inc = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_TERM: begin
        txd_n     = TERM_WORD;
        credit_n  = EIGHT_C;
        frame_inc = 1'b1;
        state_n   = ST_IDLE;
      end
      ST_DRAIN: begin
        credit_n = credit_sat;
        if (tx.s_valid && tx.s_last) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_156 or negedge rst_156_n) begin
    if (!rst_156_n) begin
      state     <= ST_IDLE;
      credit    <= IFG_C;
      txd_q     <= IDLE_WORD;
      txc_q     <= 8'hFF;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      credit    <= credit_n;
      txd_q     <= txd_n;
      txc_q     <= txc_n;
      frame_cnt <= frame_cnt + CNT_WIDTH'(frame_inc);
      err_cnt   <= err_cnt + CNT_WIDTH'(err_inc);
    end
  end

endmodule
